// File: rtl/sync_counter_pkg.sv
// Shared types and constants for the synchronous up-counter block.
// Holds the run-control state encoding and the default count width.
// Imported by up_count_core and sync_up_counter_ctrl.
package sync_counter_pkg;

    // Run-control states; encoding kept explicit so waveforms read the same everywhere.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/up_count_core.sv
// Modulo count register with clear, saturating load and wrapping increment.
// Latency: q_o updates on the clk edge sampling a command; tc_o is a compare on the register.
// No backpressure: commands are single-cycle strobes, priority clr_i > load_i > inc_i.
//
// Ports:
//   clk, reset        clock, async active-high reset (q_o -> 0)
//   clr_i             clear count to 0
//   load_i/load_val_i load min(load_val_i, MAX_COUNT)
//   inc_i             increment, wrapping MAX_COUNT -> 0
//   q_o, tc_o         current count, terminal-count flag
module up_count_core
    import sync_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            // Loads above the terminal value saturate so q never leaves 0..MAX_COUNT.
            q_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
        end else if (inc_i) begin
            q_d = (q_q == MAX_V) ? '0 : q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign tc_o = (q_q == MAX_V);

endmodule

// File: rtl/sync_up_counter_ctrl.sv
// Enable-gated modulo up-counter with IDLE/RUN/DONE run control, free-running or one-shot.
// Latency: an enabled increment shows on q one cycle after the sampling edge; tc/carry_out track q.
// No backpressure: carry_out is a same-cycle enable for a cascaded higher-order stage.
//
// Ports:
//   clk, reset         clock, async active-high reset
//   start, stop        run control (stop wins when both high)
//   en                 count enable in RUN
//   clr, load/load_val synchronous clear / saturating parallel load
//   oneshot            1 = halt in DONE at MAX_COUNT, 0 = wrap
//   q, tc, carry_out   count, terminal flag, cascade enable
//   busy, done         state == RUN, state == DONE (registered)
module sync_up_counter_ctrl
    import sync_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    state_t state_q;
    state_t state_d;
    logic   busy_q;
    logic   done_q;
    logic   core_clr;
    logic   core_load;
    logic   core_inc;

    up_count_core #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (core_clr),
        .load_i     (core_load),
        .load_val_i (load_val),
        .inc_i      (core_inc),
        .q_o        (q),
        .tc_o       (tc)
    );

    // Next state and core commands; order of the if-chain is the per-edge priority.
    always_comb begin
        state_d   = state_q;
        core_clr  = 1'b0;
        core_load = 1'b0;
        core_inc  = 1'b0;
        if (clr) begin
            core_clr = 1'b1;
            if (state_q == DONE) state_d = IDLE;
        end else if (load) begin
            core_load = 1'b1;
            if (state_q == DONE) state_d = IDLE;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = RUN;
                RUN: begin
                    if (en) begin
                        // One-shot parks at MAX_COUNT instead of wrapping.
                        if (tc && oneshot) state_d = DONE;
                        else               core_inc = 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d  = RUN;
                        core_clr = 1'b1;   // restart from 0 on the same edge
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign carry_out = tc & en & busy_q & ~oneshot;

endmodule

// File: tb/tb_sync_up_counter_ctrl.sv
module tb_sync_up_counter_ctrl;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       en;
        logic       clr;
        logic       load;
        logic       oneshot;
        logic [3:0] load_val;
    } in_t;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       co;
        logic       busy;
        logic       done;
    } out_t;

    logic clk;
    logic reset;
    in_t  in_a, in_b, in_c, in_lo;

    logic [3:0] q_a, q_b, q_c, q_lo, q_hi;
    logic tc_a, tc_b, tc_c, tc_lo, tc_hi;
    logic co_a, co_b, co_c, co_lo, co_hi;
    logic bz_a, bz_b, bz_c, bz_lo, bz_hi;
    logic dn_a, dn_b, dn_c, dn_lo, dn_hi;

    // id 0: MAX 15, id 1: MAX 9, id 2: MAX 5, id 3/4: cascaded MAX 9 pair
    sync_up_counter_ctrl #(.WIDTH(4), .MAX_COUNT(15)) dut_a (
        .clk(clk), .reset(reset), .start(in_a.start), .stop(in_a.stop), .en(in_a.en),
        .clr(in_a.clr), .load(in_a.load), .load_val(in_a.load_val), .oneshot(in_a.oneshot),
        .q(q_a), .tc(tc_a), .carry_out(co_a), .busy(bz_a), .done(dn_a));

    sync_up_counter_ctrl #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
        .clk(clk), .reset(reset), .start(in_b.start), .stop(in_b.stop), .en(in_b.en),
        .clr(in_b.clr), .load(in_b.load), .load_val(in_b.load_val), .oneshot(in_b.oneshot),
        .q(q_b), .tc(tc_b), .carry_out(co_b), .busy(bz_b), .done(dn_b));

    sync_up_counter_ctrl #(.WIDTH(4), .MAX_COUNT(5)) dut_c (
        .clk(clk), .reset(reset), .start(in_c.start), .stop(in_c.stop), .en(in_c.en),
        .clr(in_c.clr), .load(in_c.load), .load_val(in_c.load_val), .oneshot(in_c.oneshot),
        .q(q_c), .tc(tc_c), .carry_out(co_c), .busy(bz_c), .done(dn_c));

    sync_up_counter_ctrl #(.WIDTH(4), .MAX_COUNT(9)) dut_lo (
        .clk(clk), .reset(reset), .start(in_lo.start), .stop(in_lo.stop), .en(in_lo.en),
        .clr(in_lo.clr), .load(in_lo.load), .load_val(in_lo.load_val), .oneshot(in_lo.oneshot),
        .q(q_lo), .tc(tc_lo), .carry_out(co_lo), .busy(bz_lo), .done(dn_lo));

    sync_up_counter_ctrl #(.WIDTH(4), .MAX_COUNT(9)) dut_hi (
        .clk(clk), .reset(reset), .start(in_lo.start), .stop(in_lo.stop), .en(co_lo),
        .clr(in_lo.clr), .load(in_lo.load), .load_val(in_lo.load_val), .oneshot(in_lo.oneshot),
        .q(q_hi), .tc(tc_hi), .carry_out(co_hi), .busy(bz_hi), .done(dn_hi));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard queues: one entry per expected observation.
    int    exp_id[$];
    out_t  exp_val[$];
    string exp_tag[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic out_t mk(input int qv, input bit t, input bit c, input bit b, input bit d);
        out_t o;
        o.q    = 4'(qv);
        o.tc   = t;
        o.co   = c;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    function automatic out_t observe(input int id);
        case (id)
            0:       return {q_a,  tc_a,  co_a,  bz_a,  dn_a};
            1:       return {q_b,  tc_b,  co_b,  bz_b,  dn_b};
            2:       return {q_c,  tc_c,  co_c,  bz_c,  dn_c};
            3:       return {q_lo, tc_lo, co_lo, bz_lo, dn_lo};
            default: return {q_hi, tc_hi, co_hi, bz_hi, dn_hi};
        endcase
    endfunction

    task automatic expect_out(input int id, input out_t e, input string tag);
        exp_id.push_back(id);
        exp_val.push_back(e);
        exp_tag.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, drain everything the stimulus queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_id.size() > 0) begin
                int    id;
                out_t  e;
                out_t  g;
                string tg;
                id = exp_id.pop_front();
                e  = exp_val.pop_front();
                tg = exp_tag.pop_front();
                g  = observe(id);
                n_chk++;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s (dut %0d): got q=%0d tc=%0b co=%0b busy=%0b done=%0b, want q=%0d tc=%0b co=%0b busy=%0b done=%0b",
                             tg, id, g.q, g.tc, g.co, g.busy, g.done, e.q, e.tc, e.co, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_a  = '0;
        in_b  = '0;
        in_c  = '0;
        in_lo = '0;

        // Reset state of every instance
        tick();
        for (int i = 0; i < 5; i++) expect_out(i, mk(0, 0, 0, 0, 0), "reset state");
        tick();
        reset = 1'b0;

        // A: count to 7, hold with en=0, then reset between edges
        in_a.start = 1'b1;
        expect_out(0, mk(0, 0, 0, 0, 0), "A idle before start");
        tick();
        in_a.start = 1'b0;
        in_a.en    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            expect_out(0, mk(i, 0, 0, 1, 0), "A counting");
            tick();
        end
        in_a.en = 1'b0;
        expect_out(0, mk(7, 0, 0, 1, 0), "A reached 7");
        tick();
        reset = 1'b1;
        expect_out(0, mk(0, 0, 0, 0, 0), "A mid-count reset");
        tick();
        reset = 1'b0;
        in_a  = '0;

        // B: free-running wrap at 9
        in_b.start = 1'b1;
        expect_out(1, mk(0, 0, 0, 0, 0), "B idle before start");
        tick();
        in_b.start = 1'b0;
        in_b.en    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expect_out(1, mk(i % 10, (i % 10) == 9, (i % 10) == 9, 1, 0), "B free-run");
            tick();
        end

        // B: enable gating 1,0,1 from q=2
        expect_out(1, mk(2, 0, 0, 1, 0), "B gate q2");
        tick();
        in_b.en = 1'b0;
        expect_out(1, mk(3, 0, 0, 1, 0), "B gate en0");
        tick();
        in_b.en = 1'b1;
        expect_out(1, mk(3, 0, 0, 1, 0), "B gate hold");
        tick();

        // B: stop and start together -> IDLE, q holds
        in_b.stop  = 1'b1;
        in_b.start = 1'b1;
        expect_out(1, mk(4, 0, 0, 1, 0), "B gate q4");
        tick();
        in_b.stop     = 1'b0;
        in_b.start    = 1'b0;
        in_b.load     = 1'b1;
        in_b.load_val = 4'd12;
        expect_out(1, mk(4, 0, 0, 0, 0), "B stop wins");
        tick();
        in_b.clr = 1'b1;
        expect_out(1, mk(9, 1, 0, 0, 0), "B load saturates");
        tick();
        in_b = '0;
        expect_out(1, mk(0, 0, 0, 0, 0), "B clr over load");
        tick();

        // C: one-shot halt at 5, then restart
        in_c.oneshot = 1'b1;
        in_c.start   = 1'b1;
        expect_out(2, mk(0, 0, 0, 0, 0), "C idle before start");
        tick();
        in_c.start = 1'b0;
        in_c.en    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out(2, mk(i, i == 5, 0, 1, 0), "C one-shot count");
            tick();
        end
        expect_out(2, mk(5, 1, 0, 0, 1), "C done");
        tick();
        in_c.start = 1'b1;
        expect_out(2, mk(5, 1, 0, 0, 1), "C done holds");
        tick();
        in_c.start = 1'b0;
        in_c.en    = 1'b0;
        expect_out(2, mk(0, 0, 0, 1, 0), "C restart");
        tick();

        // Cascade: two MAX 9 stages, 25 enabled cycles
        in_lo.start = 1'b1;
        expect_out(3, mk(0, 0, 0, 0, 0), "LO idle");
        tick();
        in_lo.start = 1'b0;
        in_lo.en    = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 9 || i == 19) begin
                expect_out(3, mk(9, 1, 1, 1, 0), "LO wrap carry");
                expect_out(4, mk(i / 10, 0, 0, 1, 0), "HI before carry");
            end
            tick();
        end
        in_lo.en = 1'b0;
        expect_out(3, mk(5, 0, 0, 1, 0), "LO after 25");
        expect_out(4, mk(2, 0, 0, 1, 0), "HI after 25");
        tick();

        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (exp_id.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d pending, want 0", exp_id.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_up_counter_ctrl.md
Name: sync_up_counter_ctrl

Overview:
Synchronous, enable-gated modulo up-counter with load, clear and a small run-control FSM; the count-up counterpart to the team's ripple down-counter. Single clock domain; every state bit is clocked on clk, with no derived clocks. Supports free-running and one-shot modes. carry_out lets several instances cascade into wider counters.

Parameters:
WIDTH, 4, count register width in bits (1..16)
MAX_COUNT, 2**WIDTH-1, terminal value; count wraps MAX_COUNT -> 0 (must be <= 2**WIDTH-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  leave IDLE/DONE and begin counting (level sampled on clk)
stop  input  1  return to IDLE and hold count
en  input  1  count enable; increments only when high in RUN
clr  input  1  synchronous clear of count to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
oneshot  input  1  1 = halt at MAX_COUNT (DONE); 0 = wrap freely
q  output  WIDTH  current count
tc  output  1  terminal count: q == MAX_COUNT (combinational from registers)
carry_out  output  1  tc & en & (state==RUN) & ~oneshot; cascade enable
busy  output  1  state == RUN
done  output  1  state == DONE

Behaviour:
- Reset (async, any time, including mid-count): q=0, state=IDLE, busy=0, done=0, tc=0 (unless MAX_COUNT==0), carry_out=0. Release is synchronous to next clk edge in effect; first count no earlier than 2nd edge after start.
- States: IDLE, RUN, DONE.
  IDLE: q holds. start=1 -> RUN.
  RUN: if en, q <= (q==MAX_COUNT) ? 0 : q+1, unless oneshot=1 and q==MAX_COUNT -> DONE with q held at MAX_COUNT. stop=1 -> IDLE (q holds, no increment that cycle).
  DONE: q holds MAX_COUNT. start=1 -> RUN with q <= 0 same edge. stop=1 -> IDLE.
- Priority per edge: reset > clr > load > stop > start > increment.
  clr: q <= 0 in any state; state unchanged except DONE -> IDLE.
  load: q <= min(load_val, MAX_COUNT) in any state; state unchanged except DONE -> IDLE; no increment that cycle.
  stop and start same cycle: stop wins.
- Latency: q reflects an enabled increment one cycle after the edge sampling en=1. tc/carry_out valid same cycle as q.
- Wrap: free-running, q==MAX_COUNT with en -> 0 next edge; carry_out high exactly during that cycle (one-cycle pulse per wrap when en continuous).
- oneshot change while in RUN takes effect the next cycle; switching to 1 while q==MAX_COUNT and en=1 -> DONE.
- en=0 in RUN: q holds, carry_out=0, state stays RUN.
- Arithmetic: unsigned, WIDTH bits, no overflow beyond MAX_COUNT possible; loads above MAX_COUNT saturate.

Decomposition:
- Shared package sync_counter_pkg: state enum (IDLE, RUN, DONE), encoding constants, default WIDTH.
- One sub-module natural: up_count_core (count register with clr/load/inc/wrap, tc compare); the top holds the FSM and output decode.

Test Plan:
- Reset mid-count: WIDTH=4, MAX=15, count to q=7, assert reset between edges -> q=0, state IDLE immediately, busy=0.
- Free-run wrap: MAX=9, oneshot=0, start then en=1 for 12 cycles -> q 1..9,0,1,2; carry_out high only in the q=9 cycle; busy=1 throughout.
- One-shot: MAX=5, oneshot=1, en=1 -> q reaches 5, next edge done=1, busy=0, q stays 5; start -> q=0, RUN.
- Load saturation/priority: MAX=9, load=1, load_val=12, clr=0 -> q=9, tc=1; load and clr same cycle -> q=0.
- Enable gating and stop: en toggled 1,0,1 from q=2 -> q=3,3,4; stop with start same cycle -> IDLE, q holds.
- Cascade: two instances WIDTH=4 MAX=9, carry_out of low drives en of high, run 25 cycles -> high.q=2, low.q=5.
